seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed scanner for the board's common-anode 7-segment bank.
- Holds a NUM_DIGITS-nibble display value and visits one digit per refresh slot.
- For the visited digit it presents the 4-bit hex code to the downstream hex-to-7-segment decoder and drives the matching active-low digit enable.
- Supports inter-digit dead time against ghosting, and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal range 2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (legal range >= 2).
- DEAD_CYCLES, 2, cycles at the start of each slot with all digits off (legal range 0..REFRESH_DIV-1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  4*NUM_DIGITS  display value; nibble i drives digit i, digit 0 is least significant.
- load  input  1  when 1, capture value into the shadow register on this edge.
- lz_blank  input  1  when 1, suppress leading zero digits.
- hex_out  output  4  nibble for the current digit, fed to the decoder.
- digit_en  output  NUM_DIGITS  active-low digit enables; 0 = digit lit.
- slot_start  output  1  one-cycle pulse on the first cycle of each slot.

Behaviour:
- Reset (synchronous, takes priority over everything else): shadow=0, slot counter cnt=0, digit index idx=0, hex_out=0, digit_en=all ones, slot_start=0.
- Reset asserted mid-scan returns the block to this state on the next edge. After release the scan restarts at digit 0, cnt=0.
- Shadow register: loads value on an edge where load=1. load held high recaptures every cycle.
- The shadow is never updated from value otherwise; digits stay stable across slots.
- Slot counter: cnt counts 0..REFRESH_DIV-1.
  - At cnt==REFRESH_DIV-1: cnt wraps to 0 and idx advances by 1.
  - idx wraps from NUM_DIGITS-1 to 0.
- All outputs are registered. Outputs after edge k are a function of cnt, idx and the shadow as they stood before edge k (1-cycle pipeline).
- A capture at edge k is first visible on hex_out at edge k+1, and only for whichever digit is then current. There is no wait for a slot boundary.
- hex_out = shadow nibble[idx]. It is always driven, including during dead time and blanking.
- Blanking rule: digit i>0 is blanked when lz_blank=1 and shadow nibbles i..NUM_DIGITS-1 are all zero.
- Digit 0 is never blanked, so a value of 0 shows a single "0".
- digit_en: bit idx is 0 only when cnt >= DEAD_CYCLES and digit idx is not blanked. All other bits are always 1.
- At most one digit_en bit is 0 at any time.
- DEAD_CYCLES=0: the digit stays lit for the whole slot.
- slot_start = 1 for exactly the one cycle in which the registered outputs reflect cnt==0.
- Simultaneous load at a slot boundary: the new shadow is used for the next slot's first output cycle. The old and new value are never mixed within one output cycle.
- lz_blank is sampled combinationally each cycle through the same 1-cycle output register. There is no latching.
- Arithmetic: cnt width is clog2(REFRESH_DIV); idx width is clog2(NUM_DIGITS), minimum 1. Both wrap by explicit compare, never by natural overflow.

Test Plan:
(All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.)
1. Reset, then load value=16'h1A2F with lz_blank=0.
   - Slots visit digits 0,1,2,3,0.
   - hex_out = F,2,A,1; digit_en in lit cycles = 1110,1101,1011,0111.
   - First cycle of each slot has digit_en=1111 and slot_start=1.
   - Period is 16 cycles.
2. Load 16'h0050 with lz_blank=1.
   - Digits 2 and 3 stay at digit_en=1111 for their entire slots; digits 0 and 1 light.
   - With lz_blank=0, all four light.
3. Load 16'h0000 with lz_blank=1.
   - Only digit 0 lights, with hex_out=0; digits 1..3 stay 1111.
4. Pulse load with 16'h1234 during digit 1's lit cycles, previous value 16'hFFFF.
   - hex_out changes from F to 3 exactly one cycle after the capture edge, within the same slot.
5. Assert reset for 1 cycle while idx=2, cnt=3.
   - Next cycle: digit_en=1111, hex_out=0, shadow cleared.
   - Scan resumes at digit 0; the first slot_start pulse appears 1 cycle after release.
6. Hold load=1 while value toggles every cycle.
   - hex_out tracks the current digit's nibble with exactly 1-cycle lag.
   - No cycle ever has more than one digit_en bit low.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner: one digit per refresh slot,
// dead time at slot start, optional leading-zero blanking, all outputs registered.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  input  logic                      lz_blank,
  output logic [3:0]                hex_out,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      slot_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   en_next;
  logic                    upper_zero;

  // Walk from the most significant digit down: a digit is blanked while every
  // nibble from it upward is zero. Digit 0 always shows.
  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i]     = shadow[4*i +: 4];
      upper_zero = upper_zero && (nib[i] == 4'h0);
      blank[i]   = lz_blank && upper_zero && (i != 0);
    end
  end

  always_comb begin
    en_next = '1;
    if (cnt >= CNT_DEAD && !blank[idx])
      en_next[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow     <= '0;
      cnt        <= '0;
      idx        <= '0;
      hex_out    <= 4'h0;
      digit_en   <= '1;
      slot_start <= 1'b0;
    end else begin
      hex_out    <= nib[idx];
      digit_en   <= en_next;
      slot_start <= (cnt == '0);
      if (load)
        shadow <= value;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 4-cycle slots, 1 dead cycle): directed
// scenarios then random traffic, checked against a time-indexed reference model.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DC = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   value = '0;
  logic          load = 1'b0;
  logic          lz_blank = 1'b0;
  logic [3:0]    hex_out;
  logic [3:0]    digit_en;
  logic          slot_start;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: shadow contents and edges elapsed since reset.
  logic [15:0] m_shadow = '0;
  int          m_n = 0;
  logic [3:0]  exp_hex;
  logic [3:0]  exp_en;
  logic        exp_ss;

  seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .lz_blank(lz_blank),
    .hex_out(hex_out), .digit_en(digit_en), .slot_start(slot_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, predict from pre-edge state, compare after edge.
  task automatic step(input logic rst, input logic ld, input logic [15:0] v, input logic lz);
    int c, d;
    logic blk;
    @(negedge clk);
    reset = rst; load = ld; value = v; lz_blank = lz;
    @(posedge clk);
    if (rst) begin
      exp_hex = 4'h0; exp_en = 4'hF; exp_ss = 1'b0;
      m_shadow = '0; m_n = 0;
    end else begin
      c = m_n % RD;
      d = (m_n / RD) % ND;
      exp_hex = 4'((m_shadow >> (4*d)) & 16'hF);
      blk = lz && (d > 0) && ((m_shadow >> (4*d)) == 0);
      exp_en = (c >= DC && !blk) ? ~(4'b0001 << d) : 4'hF;
      exp_ss = (c == 0);
      if (ld) m_shadow = v;
      m_n++;
    end
    #1;
    check("hex_out", 32'(hex_out), 32'(exp_hex));
    check("digit_en", 32'(digit_en), 32'(exp_en));
    check("slot_start", 32'(slot_start), 32'(exp_ss));
    check("one_low", 32'($countones(~digit_en) <= 1), 32'd1);
  endtask

  task automatic idle(input int cycles, input logic lz);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, $urandom, lz);
  endtask

  task automatic run_to(input int phase, input logic lz);
    for (int i = 0; i < 64 && (m_n % (RD*ND)) != phase; i++)
      step(1'b0, 1'b0, $urandom, lz);
  endtask

  initial begin
    // Scenario 1: reset, load 1A2F, observe more than one full period.
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1A2F, 1'b0);
    idle(20, 1'b0);
    // Scenario 2: 0050 with and without blanking.
    step(1'b0, 1'b1, 16'h0050, 1'b1);
    idle(16, 1'b1);
    idle(16, 1'b0);
    // Scenario 3: all zero with blanking.
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    idle(16, 1'b1);
    // Scenario 4: FFFF then capture 1234 during digit 1's lit cycles.
    step(1'b0, 1'b1, 16'hFFFF, 1'b0);
    run_to(RD + 2, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(6, 1'b0);
    // Scenario 5: reset while idx=2, cnt=3.
    run_to(2*RD + 3, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    idle(10, 1'b0);
    // Scenario 6: load held high with value toggling.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, (i % 2) ? 16'hA5C3 : 16'h5A3C, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 16'($urandom), 1'($urandom));
    // Random traffic with sparse loads of mostly-zero-topped values and rare resets.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] v;
      v = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 2, v, 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
